reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 19 +
 rtl/reset_seq_counter.sv | 36 +++
 rtl/reset_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared reset-sequencer definitions: debug state encoding and sizing helpers.
package reset_sequencer_pkg;

    localparam int SEQ_STATE_W = 2;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SWRST   = 2'd3
    } seq_state_e;

    function automatic int cnt_width(input int stage_delay, input int pulse_min);
        int m;
        m = (stage_delay > pulse_min) ? stage_delay : pulse_min;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_counter.sv
// Loadable down-counter that saturates at zero; flags the last count and zero.
module reset_seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc   = (cnt_q == W'(1));
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with software reset request and minimum hold pulse.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int PULSE_MIN   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    output logic                   SW_RST_ACK,
    output logic [NUM_STAGES-1:0]  OUT_RST_N,
    output logic                   ALL_READY,
    output logic [SEQ_STATE_W-1:0] SEQ_STATE
);

    localparam int CNT_W = cnt_width(STAGE_DELAY, PULSE_MIN);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    seq_state_e            state_q, state_d;
    logic [NUM_STAGES-1:0] out_q, out_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  ready_q, ready_d;
    logic                  ack_q, ack_d;
    logic                  load;
    logic [CNT_W-1:0]      load_val;
    logic                  cnt_tc;
    logic                  cnt_zero;

    reset_seq_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .load_val (load_val),
        .tc       (cnt_tc),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        idx_d    = idx_q;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            ST_HOLD: begin
                if (SW_RST_REQ) begin
                    state_d  = ST_SWRST;
                    out_d    = '0;
                    idx_d    = '0;
                    load     = 1'b1;
                    load_val = CNT_W'(PULSE_MIN);
                end else if ((cnt_zero && STAGE_DELAY == 1) || cnt_tc) begin
                    out_d[0] = 1'b1;
                    load     = 1'b1;
                    if (NUM_STAGES == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d  = ST_RELEASE;
                        idx_d    = IDX_W'(1);
                        load_val = CNT_W'(STAGE_DELAY);
                    end
                end else if (cnt_zero) begin
                    // Entry with a cleared counter: the first edge itself counts.
                    load     = 1'b1;
                    load_val = CNT_W'(STAGE_DELAY - 1);
                end
            end
            ST_RELEASE: begin
                if (SW_RST_REQ) begin
                    state_d  = ST_SWRST;
                    out_d    = '0;
                    idx_d    = '0;
                    load     = 1'b1;
                    load_val = CNT_W'(PULSE_MIN);
                end else if (cnt_tc) begin
                    out_d[idx_q] = 1'b1;
                    load         = 1'b1;
                    if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        load_val = CNT_W'(STAGE_DELAY);
                    end
                end
            end
            ST_RUN: begin
                if (SW_RST_REQ) begin
                    state_d  = ST_SWRST;
                    out_d    = '0;
                    idx_d    = '0;
                    load     = 1'b1;
                    load_val = CNT_W'(PULSE_MIN);
                end
            end
            ST_SWRST: begin
                if (cnt_zero && !SW_RST_REQ) begin
                    state_d = ST_HOLD;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
        ready_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        ack_d   = (state_q == ST_SWRST) && (state_d == ST_SWRST)
                  && (cnt_zero || cnt_tc);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_HOLD;
            out_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    assign OUT_RST_N  = out_q;
    assign ALL_READY  = ready_q;
    assign SW_RST_ACK = ack_q;
    assign SEQ_STATE  = state_q;

endmodule
